operacion_sched: RTL and testbench
==================================

# operacion_sched

Sequential scheduler that shares one `operacion` arithmetic resource between two requesters in the register-bank design. Each request selects one of two operations: C=1 computes res = X + Y·X, C=0 computes res = X·X − Y. The block arbitrates round-robin and computes the product with an iterative shift-add multiplier instead of a combinational one. It returns a 16-bit result with a done pulse to the winning requester.

## Interface
- W, default 8: operand width; result width is 2W.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  2  per-port request, level; bit i = port i.
- c  in  2  per-port operation select (1: X+Y·X, 0: X·X−Y).
- x0, y0  in  W  port 0 operands.
- x1, y1  in  W  port 1 operands.
- ack  out  2  one-cycle acceptance pulse per port.
- done  out  2  one-cycle completion pulse per port.
- res0, res1  out  2W  per-port result register, held until overwritten.
- busy  out  1  high in any state except IDLE.

## Operation
- States:
  - IDLE: waits for a request. If any req bit is high, the grant is chosen, the operands and c of that port are latched, and the state moves to MUL.
  - MUL: runs 8 shift-add iterations (counter 0..7), then moves to FIN.
  - FIN: applies the final add or subtract, then moves to DONE.
  - DONE: pulses done for the granted port, then returns to IDLE.
- Arbitration: round-robin on a last-served pointer.
  - If only one req is high, that port wins.
  - If both are high, the port not served last wins.
  - After reset the pointer favours port 0.
- Multiplier: multiplicand = X; multiplier = Y when c=1, X when c=0. The unsigned product P is 2W bits.
- FIN:
  - c=1: res = P + X (zero-extended). The maximum value 0xFF00 fits in 2W bits; there is no overflow.
  - c=0: res = P − Y, modulo 2^(2W). An underflow wraps with no flag (X=0, Y=5 → 0xFFFB).
- Result is written only to the granted port's res register; the other port's register is unchanged.
- Handshake:
  - Requester holds req, c and operands stable until its ack.
  - Requester deasserts req in the cycle after ack.
  - A req still high when the block is in IDLE is a new request.
  - Operands are latched at acceptance, so changes after ack have no effect.
- Requests arriving while busy are ignored until IDLE. There is no queueing and no lost state; req is simply held.
- Reset, including mid-operation:
  - State goes to IDLE, counter to 0, pointer to favour port 0.
  - ack=0, done=0, busy=0, res0=res1=0.
  - The in-flight operation is discarded and no done is issued.

## Timing
- Edge E0 (IDLE, req high) is the acceptance edge.
- ack[i] is registered and is high in the cycle after E0.
- MUL occupies the 8 cycles after E0; FIN is the 9th cycle.
- res_i is updated at the end of FIN.
- done[i] is high in the 10th cycle after E0 (DONE state); res_i is already valid in that cycle.
- Next acceptance is possible at the edge ending the first IDLE cycle after DONE.
- Back-to-back throughput: one operation per 11 cycles.
- busy is high from the cycle after E0 through the DONE cycle inclusive.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `operacion_pkg`:
  - state enum {IDLE, MUL, FIN, DONE}.
  - W default.
  - Iteration count constant (= W).
  - Port index constants.
- Sub-module `operacion_mul_iter`: W×W iterative shift-add multiplier.
  - Inputs: start, multiplicand, multiplier.
  - Outputs: product, valid after W cycles.
- The arbiter and FSM live in the top level.

## Test plan
- Port 0, X=3, Y=4, c=1 → ack[0] one cycle after accept; done[0] 10 cycles after accept; res0=15; res1 stays 0.
- Port 1, X=3, Y=4, c=0 → res1=5; done[1] only; ack[0] and done[0] never assert.
- Port 0, X=0, Y=5, c=0 → res0=0xFFFB. Then X=255, Y=255, c=1 → res0=0xFF00.
- Both req high in the same IDLE cycle after reset → port 0 served first, port 1 second. Repeat with both high again → port 0 wins again, because port 1 was served last.
- Port 1 request, operands changed right after ack → result uses the latched operands; busy high for exactly 10 cycles.
- rst_n low during MUL cycle 4 → outputs zero immediately (asynchronous), no done. After release, a new request completes normally with the correct result.

Source files
------------

// File: rtl/operacion_pkg.sv
// Shared types and constants for the operacion scheduler and its
// iterative multiplier.
package operacion_pkg;

  localparam int W_DEF = 8;
  localparam int ITER  = W_DEF;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/operacion_mul_iter.sv
// W x W unsigned shift-add multiplier: one partial product per cycle,
// product valid W cycles after start.
module operacion_mul_iter
  import operacion_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [W-1:0]   mcand_i,
  input  logic [W-1:0]   mplier_i,
  output logic [2*W-1:0] product_o,
  output logic           valid_o
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           run_q, run_d;
  logic           valid_q, valid_d;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    valid_d  = valid_q;
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = {{W{1'b0}}, mcand_i};
      mplier_d = mplier_i;
      cnt_d    = '0;
      run_d    = 1'b1;
      valid_d  = 1'b0;
    end else if (run_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        run_d   = 1'b0;
        valid_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      valid_q  <= valid_d;
    end
  end

  assign product_o = acc_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/operacion_sched.sv
// Round-robin scheduler sharing one operacion unit (X+Y*X or X*X-Y)
// between two requesters; IDLE -> MUL (W cycles) -> FIN -> DONE.
module operacion_sched
  import operacion_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req,
  input  logic [1:0]     c,
  input  logic [W-1:0]   x0,
  input  logic [W-1:0]   y0,
  input  logic [W-1:0]   x1,
  input  logic [W-1:0]   y1,
  output logic [1:0]     ack,
  output logic [1:0]     done,
  output logic [2*W-1:0] res0,
  output logic [2*W-1:0] res1,
  output logic           busy
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           last_q, last_d;
  logic           gnt_q, gnt_d;
  logic           c_q, c_d;
  logic [W-1:0]   x_q, x_d, y_q, y_d;
  logic [1:0]     ack_q, ack_d, done_q, done_d;
  logic [2*W-1:0] res0_q, res0_d, res1_q, res1_d;
  logic           busy_q, busy_d;

  logic           accept;
  logic           gnt_sel;
  logic [W-1:0]   x_sel, y_sel;
  logic [2*W-1:0] product;
  logic           mul_valid;
  logic [2*W-1:0] fin_val;

  // Ties go to the port that was not served last.
  always_comb begin
    case (req)
      2'b01:   gnt_sel = PORT0;
      2'b10:   gnt_sel = PORT1;
      2'b11:   gnt_sel = ~last_q;
      default: gnt_sel = PORT0;
    endcase
  end

  assign accept = (state_q == S_IDLE) && (|req);
  assign x_sel  = (gnt_sel == PORT1) ? x1 : x0;
  assign y_sel  = (gnt_sel == PORT1) ? y1 : y0;

  operacion_mul_iter #(.W(W)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (accept),
    .mcand_i   (x_sel),
    .mplier_i  (c[gnt_sel] ? y_sel : x_sel),
    .product_o (product),
    .valid_o   (mul_valid)
  );

  assign fin_val = c_q ? (product + {{W{1'b0}}, x_q})
                       : (product - {{W{1'b0}}, y_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|req) state_d = S_MUL;
      S_MUL:   if (cnt_q == CNT_LAST) state_d = S_FIN;
      S_FIN:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    gnt_d  = gnt_q;
    c_d    = c_q;
    x_d    = x_q;
    y_d    = y_q;
    ack_d  = 2'b00;
    done_d = 2'b00;
    res0_d = res0_q;
    res1_d = res1_q;
    busy_d = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          gnt_d          = gnt_sel;
          last_d         = gnt_sel;
          c_d            = c[gnt_sel];
          x_d            = x_sel;
          y_d            = y_sel;
          ack_d[gnt_sel] = 1'b1;
        end
      end
      S_MUL: cnt_d = cnt_q + 1'b1;
      S_FIN: begin
        if (mul_valid) begin
          if (gnt_q == PORT1) res1_d = fin_val;
          else                res0_d = fin_val;
        end
        done_d[gnt_q] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      last_q <= PORT1;
      gnt_q  <= PORT0;
      c_q    <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      ack_q  <= 2'b00;
      done_q <= 2'b00;
      res0_q <= '0;
      res1_q <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
      gnt_q  <= gnt_d;
      c_q    <= c_d;
      x_q    <= x_d;
      y_q    <= y_d;
      ack_q  <= ack_d;
      done_q <= done_d;
      res0_q <= res0_d;
      res1_q <= res1_d;
      busy_q <= busy_d;
    end
  end

  assign ack  = ack_q;
  assign done = done_q;
  assign res0 = res0_q;
  assign res1 = res1_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_operacion_sched.sv
// Directed bench for operacion_sched: single ops, round-robin ties,
// operand stability after ack, and asynchronous reset mid-operation.
module tb_operacion_sched;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     req, c;
  logic [W-1:0]   x0, y0, x1, y1;
  logic [1:0]     ack, done;
  logic [2*W-1:0] res0, res1;
  logic           busy;

  int n_checks = 0;
  int n_errors = 0;

  int             ack_cyc [2];
  int             done_cyc[2];
  int             ack_cnt [2];
  int             done_cnt[2];
  logic [2*W-1:0] res_at_done[2];
  int             busy_cnt;

  operacion_sched #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .c     (c),
    .x0    (x0),
    .y0    (y0),
    .x1    (x1),
    .y1    (y1),
    .ack   (ack),
    .done  (done),
    .res0  (res0),
    .res1  (res1),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observes n cycles after the acceptance edge (k=1 is the cycle after E0).
  // A requester drops req as soon as it sees its ack; optionally scrambles operands.
  task automatic watch(input int n, input bit scramble);
    for (int i = 0; i < 2; i++) begin
      ack_cyc[i] = -1; done_cyc[i] = -1;
      ack_cnt[i] = 0;  done_cnt[i] = 0;
      res_at_done[i] = '0;
    end
    busy_cnt = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      for (int p = 0; p < 2; p++) begin
        if (ack[p]) begin
          ack_cnt[p]++;
          if (ack_cyc[p] < 0) ack_cyc[p] = k;
          req[p] = 1'b0;
          if (scramble) begin
            if (p == 1) begin x1 = 8'd1; y1 = 8'd1; c[1] = ~c[1]; end
            else        begin x0 = 8'd1; y0 = 8'd1; c[0] = ~c[0]; end
          end
        end
        if (done[p]) begin
          done_cnt[p]++;
          if (done_cyc[p] < 0) begin
            done_cyc[p] = k;
            res_at_done[p] = (p == 1) ? res1 : res0;
          end
        end
      end
    end
  endtask

  task automatic single(input string tag, input int p, input logic cc,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2*W-1:0] exp, input bit scramble);
    int q;
    q = 1 - p;
    if (p == 1) begin x1 = x; y1 = y; end
    else        begin x0 = x; y0 = y; end
    c[p]   = cc;
    req[p] = 1'b1;
    watch(12, scramble);
    check({tag, "_ack_cyc"},  ack_cyc[p], 1);
    check({tag, "_done_cyc"}, done_cyc[p], 10);
    check({tag, "_res"},      res_at_done[p], exp);
    check({tag, "_ack_cnt"},  ack_cnt[p], 1);
    check({tag, "_done_cnt"}, done_cnt[p], 1);
    check({tag, "_other_ack"},  ack_cnt[q], 0);
    check({tag, "_other_done"}, done_cnt[q], 0);
    check({tag, "_busy_cycles"}, busy_cnt, 10);
  endtask

  task automatic both(input string tag,
                      input logic c0v, input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [2*W-1:0] e0,
                      input logic c1v, input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [2*W-1:0] e1);
    x0 = a0; y0 = b0; x1 = a1; y1 = b1;
    c   = {c1v, c0v};
    req = 2'b11;
    watch(23, 1'b0);
    check({tag, "_p0_ack"},  ack_cyc[0], 1);
    check({tag, "_p0_done"}, done_cyc[0], 10);
    check({tag, "_p0_res"},  res_at_done[0], e0);
    check({tag, "_p1_ack"},  ack_cyc[1], 12);
    check({tag, "_p1_done"}, done_cyc[1], 21);
    check({tag, "_p1_res"},  res_at_done[1], e1);
    check({tag, "_busy_cycles"}, busy_cnt, 20);
  endtask

  initial begin
    rst_n = 1'b0;
    req = 2'b00; c = 2'b00;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    repeat (3) @(negedge clk);
    check("rst_ack",  ack, 2'b00);
    check("rst_done", done, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_res0", res0, 16'h0000);
    check("rst_res1", res1, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    single("p0_add", 0, 1'b1, 8'd3, 8'd4, 16'd15, 1'b0);
    check("p0_add_res1_untouched", res1, 16'h0000);

    single("p1_sub", 1, 1'b0, 8'd3, 8'd4, 16'd5, 1'b0);
    check("p1_sub_res0_untouched", res0, 16'd15);

    single("p0_wrap", 0, 1'b0, 8'd0, 8'd5, 16'hFFFB, 1'b0);
    single("p0_max",  0, 1'b1, 8'd255, 8'd255, 16'hFF00, 1'b0);

    // 10*7+10 = 80; operands are scrambled right after ack.
    single("p1_latch", 1, 1'b1, 8'd10, 8'd7, 16'd80, 1'b1);
    check("p1_latch_res0_kept", res0, 16'hFF00);

    // Asynchronous reset during MUL cycle 4.
    x0 = 8'd9; y0 = 8'd9; c[0] = 1'b1; req[0] = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      req[0] = 1'b0;
    end
    check("mid_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ack",  ack, 2'b00);
    check("mid_rst_done", done, 2'b00);
    check("mid_rst_res0", res0, 16'h0000);
    check("mid_rst_res1", res1, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    watch(12, 1'b0);
    check("post_rst_no_done0", done_cnt[0], 0);
    check("post_rst_no_done1", done_cnt[1], 0);
    check("post_rst_idle",     busy_cnt, 0);

    // Pointer favours port 0 after reset; then port 1 was last, so port 0 again.
    both("tie1", 1'b1, 8'd2, 8'd3, 16'd8,  1'b0, 8'd4, 8'd2, 16'd14);
    both("tie2", 1'b0, 8'd5, 8'd6, 16'd19, 1'b1, 8'd7, 8'd8, 16'd63);

    single("post_rst_p1", 1, 1'b0, 8'd6, 8'd6, 16'd30, 1'b0);
    check("final_res0", res0, 16'd19);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
